// File: rtl/evolved_circuit_evaluator.sv
// Stimulus/response wrapper for one evolved 4-input LCELL circuit: sweeps all 16 input
// vectors, majority-samples the synchronized output and scores it against a target table.
module evolved_circuit_evaluator #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [4:0]  match_count,
  output logic [4:0]  unstable_count,
  output logic [15:0] result_map
);
  localparam int MAX_HOLD = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
  localparam int CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [3:0]       SAMPLES_4   = 4'(NUM_SAMPLES);
  localparam logic [4:0]       SAMPLES_5   = 5'(NUM_SAMPLES);

  generate
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 3 to cover the output synchronizer");
    end
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 15) begin : g_bad_samples
      $error("NUM_SAMPLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_ones;
  logic [15:0]      r_exp;
  logic             r_sync1;
  logic             r_sync2;
  logic [3:0]       r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic [4:0]       r_match;
  logic [4:0]       r_unstable;
  logic [15:0]      r_map;

  logic [3:0] w_ones_total;
  logic       w_majority;
  logic       w_unstable;
  logic       w_match;

  // Includes the sample taken in the current cycle, so the last SAMPLE cycle sees the full tally.
  assign w_ones_total = r_ones + {3'b000, r_sync2};
  assign w_majority   = {1'b0, w_ones_total} + {1'b0, w_ones_total} > SAMPLES_5;
  assign w_unstable   = (w_ones_total != 4'd0) && (w_ones_total != SAMPLES_4);
  assign w_match      = (w_majority == r_exp[r_dut_in]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ones     <= '0;
      r_exp      <= '0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_dut_in   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= '0;
      r_unstable <= '0;
      r_map      <= '0;
    end else begin
      r_sync1 <= dut_out;
      r_sync2 <= r_sync1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_exp      <= expected;
            r_match    <= '0;
            r_unstable <= '0;
            r_map      <= '0;
            r_dut_in   <= '0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_ones     <= '0;
            r_state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_ones  <= '0;
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (r_cnt == SAMPLE_LAST) begin
            r_map[r_dut_in] <= w_majority;
            r_match         <= r_match + {4'b0000, w_match};
            r_unstable      <= r_unstable + {4'b0000, w_unstable};
            r_cnt           <= '0;
            r_ones          <= '0;
            if (r_dut_in == 4'd15) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dut_in <= r_dut_in + 4'd1;
              r_state  <= SETTLE;
            end
          end else begin
            r_ones <= w_ones_total;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dut_in         = r_dut_in;
  assign busy           = r_busy;
  assign done           = r_done;
  assign match_count    = r_match;
  assign unstable_count = r_unstable;
  assign result_map     = r_map;
endmodule

// File: tb/tb_evolved_circuit_evaluator.sv
// Directed bench: two evaluators (NUM_SAMPLES=4 and 3) share start/expected and drive
// selectable circuit stubs; results are checked against hand-computed values.
module tb_evolved_circuit_evaluator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] expected = 16'h0000;
  int          mode = 0;   // 0: xor parity, 1: constant 1, 2: toggle while dut_in==5

  logic [3:0]  dut_in, dut_in3;
  logic        dut_out, dut_out3;
  logic        busy, busy3, done, done3;
  logic [4:0]  match_count, match_count3, unstable_count, unstable_count3;
  logic [15:0] result_map, result_map3;
  logic        tog = 1'b0;
  logic        tog3 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  evolved_circuit_evaluator u_dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .match_count(match_count), .unstable_count(unstable_count), .result_map(result_map)
  );

  evolved_circuit_evaluator #(.SETTLE_CYCLES(4), .NUM_SAMPLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3), .done(done3),
    .match_count(match_count3), .unstable_count(unstable_count3), .result_map(result_map3)
  );

  always @(posedge clk) begin
    tog  <= (dut_in  == 4'd5) ? ~tog  : 1'b0;
    tog3 <= (dut_in3 == 4'd5) ? ~tog3 : 1'b0;
  end

  // The 3-sample stub uses the opposite toggle phase so its window catches two ones.
  assign dut_out  = (mode == 0) ? ^dut_in  : (mode == 1) ? 1'b1 : ((dut_in  == 4'd5) & tog);
  assign dut_out3 = (mode == 0) ? ^dut_in3 : (mode == 1) ? 1'b1 : ((dut_in3 == 4'd5) & ~tog3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Cycle 0 is the cycle whose closing edge sees start=1; outputs sampled at negedge.
  task automatic run_eval(input logic [15:0] exp, input int pulse_cyc, input int chg_cyc,
                          input int rst_cyc, output int done_at, output int done_n,
                          output int done3_at, output logic busy128, output logic busy129);
    done_at = -1; done_n = 0; done3_at = -1; busy128 = 1'b0; busy129 = 1'b1;
    @(negedge clk);
    expected = exp;
    start = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      start = (c == pulse_cyc) ? 1'b1 : 1'b0;
      if (c == chg_cyc) expected = ~exp;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (done3 && done3_at < 0) done3_at = c;
      if (c == 128) busy128 = busy;
      if (c == 129) busy129 = busy;
      if (c == rst_cyc) rst = 1'b1;
      if (c == rst_cyc + 1) begin
        rst = 1'b0;
        check("rst_mid dut_in", 32'(dut_in), 32'd0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid match", 32'(match_count), 32'd0);
        check("rst_mid unstable", 32'(unstable_count), 32'd0);
        check("rst_mid map", 32'(result_map), 32'd0);
      end
    end
  endtask

  initial begin
    int d_at, d_n, d3_at;
    logic b128, b129;
    repeat (3) @(negedge clk);
    check("reset dut_in", 32'(dut_in), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset match", 32'(match_count), 32'd0);
    check("reset unstable", 32'(unstable_count), 32'd0);
    check("reset map", 32'(result_map), 32'd0);
    rst = 1'b0;

    mode = 0;
    run_eval(16'h6996, -1, -1, -1, d_at, d_n, d3_at, b128, b129);
    check("xor done_at", 32'(d_at), 32'd129);
    check("xor done_width", 32'(d_n), 32'd1);
    check("xor busy@128", 32'(b128), 32'd1);
    check("xor busy@129", 32'(b129), 32'd0);
    check("xor map", 32'(result_map), 32'h6996);
    check("xor match", 32'(match_count), 32'd16);
    check("xor unstable", 32'(unstable_count), 32'd0);
    check("xor final dut_in", 32'(dut_in), 32'd15);
    check("ns3 done_at", 32'(d3_at), 32'd113);

    run_eval(16'h9669, -1, -1, -1, d_at, d_n, d3_at, b128, b129);
    check("xor_inv match", 32'(match_count), 32'd0);
    check("xor_inv unstable", 32'(unstable_count), 32'd0);
    check("xor_inv map", 32'(result_map), 32'h6996);

    mode = 1;
    run_eval(16'h00FF, -1, -1, -1, d_at, d_n, d3_at, b128, b129);
    check("const1 match", 32'(match_count), 32'd8);
    check("const1 map", 32'(result_map), 32'hFFFF);
    check("const1 unstable", 32'(unstable_count), 32'd0);

    mode = 2;
    run_eval(16'h0000, -1, -1, -1, d_at, d_n, d3_at, b128, b129);
    check("toggle4 unstable", 32'(unstable_count), 32'd1);
    check("toggle4 map", 32'(result_map), 32'h0000);
    check("toggle4 match", 32'(match_count), 32'd16);
    check("toggle3 unstable", 32'(unstable_count3), 32'd1);
    check("toggle3 map", 32'(result_map3), 32'h0020);
    check("toggle3 match", 32'(match_count3), 32'd15);

    mode = 0;
    run_eval(16'h6996, 40, 50, -1, d_at, d_n, d3_at, b128, b129);
    check("restart done_at", 32'(d_at), 32'd129);
    check("restart done_width", 32'(d_n), 32'd1);
    check("restart map", 32'(result_map), 32'h6996);
    check("restart match", 32'(match_count), 32'd16);

    run_eval(16'h6996, -1, -1, 60, d_at, d_n, d3_at, b128, b129);
    check("rst_mid done_count", 32'(d_n), 32'd0);

    run_eval(16'h6996, -1, -1, -1, d_at, d_n, d3_at, b128, b129);
    check("fresh done_at", 32'(d_at), 32'd129);
    check("fresh map", 32'(result_map), 32'h6996);
    check("fresh match", 32'(match_count), 32'd16);
    check("fresh unstable", 32'(unstable_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
